pair_triple_detector_stream: RTL



---
 rtl/pair_triple_detector_stream.sv | 121 ++++++++++++
 1 files changed

// File: rtl/pair_triple_detector_stream.sv
// Streaming pair/triple popcount detector with a one-entry val/rdy output stage
// and run/hit statistics (saturating) plus a sustained-detection flag.
module pair_triple_detector_stream #(
    parameter int unsigned W     = 8,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned HOLD  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_val,
    output logic                     in_rdy,
    input  logic [W-1:0]             in_data,
    input  logic [1:0]               mode,
    input  logic [$clog2(W+1)-1:0]   thresh,
    input  logic                     clear,
    output logic                     out_val,
    input  logic                     out_rdy,
    output logic                     out_det,
    output logic [$clog2(W+1)-1:0]   out_pop,
    output logic [CNT_W-1:0]         run_count,
    output logic                     sustained,
    output logic [CNT_W-1:0]         hit_count
);

    localparam int unsigned P_W = $clog2(W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] HOLD_C  = CNT_W'(HOLD);

    logic             out_val_q, out_val_d;
    logic             out_det_q, out_det_d;
    logic [P_W-1:0]   out_pop_q, out_pop_d;
    logic [CNT_W-1:0] run_count_q, run_count_d;
    logic [CNT_W-1:0] hit_count_q, hit_count_d;
    logic             sustained_q, sustained_d;

    logic             in_xfer;
    logic             out_xfer;
    logic [P_W-1:0]   pop_c;
    logic             det_c;

    assign in_rdy   = !out_val_q || out_rdy;
    assign in_xfer  = in_val && in_rdy;
    assign out_xfer = out_val_q && out_rdy;

    // Population count of the incoming sample
    always_comb begin
        pop_c = '0;
        for (int i = 0; i < W; i++) begin
            pop_c = pop_c + P_W'(in_data[i]);
        end
    end

    // Classification; thresh > W can never be reached by pop_c
    always_comb begin
        det_c = 1'b0;
        case (mode)
            2'b00: det_c = (pop_c == P_W'(2));
            2'b01: det_c = (pop_c == P_W'(3));
            2'b10: det_c = (pop_c == P_W'(2)) || (pop_c == P_W'(3));
            2'b11: det_c = (pop_c >= thresh);
            default: det_c = 1'b0;
        endcase
    end

    // Output stage and statistics next-state; clear wins over any update
    always_comb begin
        out_val_d   = out_val_q;
        out_det_d   = out_det_q;
        out_pop_d   = out_pop_q;
        run_count_d = run_count_q;
        hit_count_d = hit_count_q;

        if (in_xfer) begin
            out_val_d = 1'b1;
            out_det_d = det_c;
            out_pop_d = pop_c;
            if (det_c) begin
                hit_count_d = (hit_count_q == CNT_MAX) ? CNT_MAX : hit_count_q + CNT_W'(1);
                run_count_d = (run_count_q == CNT_MAX) ? CNT_MAX : run_count_q + CNT_W'(1);
            end else begin
                run_count_d = '0;
            end
        end else if (out_xfer) begin
            out_val_d = 1'b0;
        end

        sustained_d = (run_count_d >= HOLD_C);

        if (clear) begin
            run_count_d = '0;
            hit_count_d = '0;
            sustained_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_val_q   <= 1'b0;
            out_det_q   <= 1'b0;
            out_pop_q   <= '0;
            run_count_q <= '0;
            hit_count_q <= '0;
            sustained_q <= 1'b0;
        end else begin
            out_val_q   <= out_val_d;
            out_det_q   <= out_det_d;
            out_pop_q   <= out_pop_d;
            run_count_q <= run_count_d;
            hit_count_q <= hit_count_d;
            sustained_q <= sustained_d;
        end
    end

    assign out_val   = out_val_q;
    assign out_det   = out_det_q;
    assign out_pop   = out_pop_q;
    assign run_count = run_count_q;
    assign hit_count = hit_count_q;
    assign sustained = sustained_q;

endmodule
